mtm_alu_rsp_rx: RTL and testbench
=================================

MTM_ALU_RSP_RX -- requirements
Module: mtm_alu_rsp_rx

Interface
REQ-001 SHALL have parameter GAP_TIMEOUT, default 64, max idle cycles allowed between frames inside one response.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sout, input, 1, serial line from the ALU's sout; idle high; one bit per clk.
REQ-005 SHALL have port rsp_valid, output, 1, held-response valid.
REQ-006 SHALL have port rsp_ready, input, 1, consumer accepts the held response.
REQ-007 SHALL have port rsp_is_err, output, 1, held response is an error frame.
REQ-008 SHALL have port rsp_c, output, 32, result C; 0 for error responses.
REQ-009 SHALL have port rsp_flags, output, 4, {carry, overflow, zero, negative}; 0 for error responses.
REQ-010 SHALL have port rsp_err_flags, output, 6, error-frame flags; 0 for data responses.
REQ-011 SHALL have port rsp_chk_ok, output, 1, CRC3 (data) or parity (error) matched.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on any framing/protocol/timeout abort.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a completed response is dropped.

Function
REQ-014 SHALL define a frame as start bit 0, type bit (0=DATA, 1=CTL), 8 payload bits MSB first, stop bit 1: 11 bits total, sampled one per clk.
REQ-015 SHALL use frame FSM IDLE -> BITS on sout=0 in IDLE; BITS counts 10 bits; after the 10th bit, returns to IDLE.
REQ-016 SHALL treat stop bit 0 as framing error: pulse frame_err, discard partial response, reset word counter.
REQ-017 SHALL define a data response as 4 DATA frames (C bytes, MSB byte first) then 1 CTL frame with payload {0, flags[3:0], crc[2:0]}.
REQ-018 SHALL define an error response as 1 CTL frame with payload {1, err_flags[5:0], parity}, where parity is XOR of payload[7:1].
REQ-019 SHALL compute CRC3 with polynomial x^3+x+1, init 3'b000, over the 37 bits {C[31:0], 1'b0, flags[3:0]}, MSB first.
REQ-020 SHALL keep word counter 0..4; any frame whose type or payload bit 7 does not match the expected position SHALL abort with frame_err. This covers CTL with bit7=0 at count 0-3, CTL with bit7=1 at count 1-4, and DATA at count 4.
REQ-021 SHALL, with word counter >0 and FSM in IDLE for GAP_TIMEOUT consecutive cycles, abort with frame_err and reset the word counter.
REQ-022 SHALL load the output registers and set rsp_valid on the cycle after the final stop bit of a valid response.
REQ-023 SHALL clear rsp_valid on a clk edge where rsp_valid && rsp_ready.
REQ-024 SHALL, on a response completing while rsp_valid && !rsp_ready, keep the held response unchanged, drop the new one, and pulse overrun.
REQ-025 SHALL, when completion and handshake coincide, accept the old response and load the new one with rsp_valid staying 1 and no overrun.
REQ-026 SHALL report errors via rsp_chk_ok=0 rather than by dropping; a CRC or parity mismatch is not a frame_err.

Reset
REQ-027 SHALL, on rst_n low, immediately force FSM=IDLE, word counter=0, gap counter=0, and all outputs to 0, including mid-frame.
REQ-028 SHALL, after reset release, ignore sout until first sampling it high, so a line held low is not taken as a start bit.

Structure
REQ-029 SHALL place in shared package alu_pkg: frame type enum {DATA, CTL}, FSM state enum, CRC3 function, and the frame length constant 11.
REQ-030 SHALL contain one sub-module, mtm_alu_frame_rx, holding bit FSM and shift register, emitting {type, payload, stop_ok} with a one-cycle strobe.

Verification
REQ-031 SHALL cover: data response C=32'h0000_0003, flags=4'b0000, correct CRC -> rsp_valid, rsp_c=3, rsp_chk_ok=1, is_err=0.
REQ-032 SHALL cover: same response with CRC bit 0 inverted -> rsp_valid, rsp_c=3, rsp_chk_ok=0, no frame_err.
REQ-033 SHALL cover: error CTL payload 8'b1_100100_1 -> rsp_is_err=1, rsp_err_flags=6'b100100, rsp_chk_ok=1.
REQ-034 SHALL cover: 2 DATA frames then sout high for 64 cycles -> frame_err pulse; next full response is received correctly.
REQ-035 SHALL cover: two responses back-to-back with rsp_ready=0 -> first held, overrun pulses once, rsp_c equals first C.
REQ-036 SHALL cover: rst_n low during byte 3 of a response -> outputs 0 immediately; later clean response decoded correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, constants and the CRC3 helper for the mtm_alu response receiver.
package alu_pkg;

    // Serial frame: start, type, 8 payload bits, stop.
    localparam int FRAME_LEN  = 11;
    // Number of DATA frames carrying result C in a data response.
    localparam int DATA_WORDS = 4;

    typedef enum logic {
        FT_DATA = 1'b0,
        FT_CTL  = 1'b1
    } frame_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BITS = 1'b1
    } rx_state_e;

    // CRC3, polynomial x^3+x+1, init 0, over {C, 1'b0, flags} MSB first.
    function automatic logic [2:0] crc3(input logic [31:0] c, input logic [3:0] flags);
        logic [36:0] msg;
        logic [2:0]  crc;
        logic        fb;
        msg = {c, 1'b0, flags};
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ msg[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Bit-level receiver: finds a start bit, collects type + payload + stop,
// and presents the decoded frame with a one-cycle strobe on the stop-bit cycle.
module mtm_alu_frame_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sout,
    output logic       o_idle,
    output logic       o_strobe,
    output logic       o_type,
    output logic [7:0] o_payload,
    output logic       o_stop_ok
);

    // Bit index of the stop bit once in ST_BITS (type is index 0).
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 2);

    rx_state_e  r_state;
    rx_state_e  w_state_nxt;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_bit_cnt_nxt;
    logic [8:0] r_shift;
    logic [8:0] w_shift_nxt;
    logic       r_armed;

    // State, bit counter, shift register and line-armed flag.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            // A line held low out of reset must not look like a start bit.
            r_armed   <= r_armed | i_sout;
        end
    end

    // Next-state logic and the frame-complete strobe.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        o_strobe      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !i_sout) begin
                    w_state_nxt   = ST_BITS;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_BITS: begin
                if (r_bit_cnt == LAST_BIT) begin
                    o_strobe    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_shift_nxt   = {r_shift[7:0], i_sout};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_idle    = (r_state == ST_IDLE);
    assign o_type    = r_shift[8];
    assign o_payload = r_shift[7:0];
    assign o_stop_ok = i_sout;

endmodule

// File: rtl/mtm_alu_rsp_rx.sv
// Response receiver for the mtm_alu serial output: assembles data or error
// responses from frames, checks CRC/parity, and holds the result for a
// valid/ready consumer.
module mtm_alu_rsp_rx
    import alu_pkg::*;
#(
    parameter int GAP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_is_err,
    output logic [31:0] rsp_c,
    output logic [3:0]  rsp_flags,
    output logic [5:0]  rsp_err_flags,
    output logic        rsp_chk_ok,
    output logic        frame_err,
    output logic        overrun
);

    localparam int               GAP_W     = $clog2(GAP_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [2:0]       LAST_WORD = 3'(DATA_WORDS);

    logic             w_idle;
    logic             w_strobe;
    logic             w_type;
    logic [7:0]       w_payload;
    logic             w_stop_ok;

    logic [2:0]       r_word_cnt;
    logic [2:0]       w_word_cnt_nxt;
    logic [31:0]      r_c_acc;
    logic [31:0]      w_c_acc_nxt;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             w_gap_hit;
    logic             w_abort;
    logic             w_done;
    logic             w_new_is_err;
    logic [31:0]      w_new_c;
    logic [3:0]       w_new_flags;
    logic [5:0]       w_new_err_flags;
    logic             w_new_chk_ok;

    mtm_alu_frame_rx u_frame_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_sout    (sout),
        .o_idle    (w_idle),
        .o_strobe  (w_strobe),
        .o_type    (w_type),
        .o_payload (w_payload),
        .o_stop_ok (w_stop_ok)
    );

    // Classify each completed frame against the expected word position.
    always_comb begin
        w_abort         = 1'b0;
        w_done          = 1'b0;
        w_new_is_err    = 1'b0;
        w_new_c         = '0;
        w_new_flags     = '0;
        w_new_err_flags = '0;
        w_new_chk_ok    = 1'b0;
        w_word_cnt_nxt  = r_word_cnt;
        w_c_acc_nxt     = r_c_acc;
        w_gap_hit       = w_idle && (r_word_cnt != '0) && (r_gap_cnt == GAP_LAST);

        if (w_strobe) begin
            if (!w_stop_ok) begin
                w_abort = 1'b1;
            end else if (r_word_cnt != LAST_WORD) begin
                if (w_type == FT_DATA) begin
                    w_c_acc_nxt    = {r_c_acc[23:0], w_payload};
                    w_word_cnt_nxt = r_word_cnt + 3'd1;
                end else if (r_word_cnt == '0 && w_payload[7]) begin
                    // Error response: {1, err_flags[5:0], parity}.
                    w_done          = 1'b1;
                    w_new_is_err    = 1'b1;
                    w_new_err_flags = w_payload[6:1];
                    w_new_chk_ok    = ((^w_payload[7:1]) == w_payload[0]);
                end else begin
                    w_abort = 1'b1;
                end
            end else begin
                if (w_type == FT_CTL && !w_payload[7]) begin
                    // Data response trailer: {0, flags[3:0], crc[2:0]}.
                    w_done       = 1'b1;
                    w_new_c      = r_c_acc;
                    w_new_flags  = w_payload[6:3];
                    w_new_chk_ok = (crc3(r_c_acc, w_payload[6:3]) == w_payload[2:0]);
                end else begin
                    w_abort = 1'b1;
                end
            end
        end else if (w_gap_hit) begin
            w_abort = 1'b1;
        end

        if (w_abort || w_done) begin
            w_word_cnt_nxt = '0;
        end
    end

    // Word counter and C accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_c_acc    <= '0;
        end else begin
            r_word_cnt <= w_word_cnt_nxt;
            r_c_acc    <= w_c_acc_nxt;
        end
    end

    // Consecutive idle cycles while a response is partially received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else if (!w_idle || r_word_cnt == '0 || w_gap_hit) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
    end

    // Held response with valid/ready handshake, overrun and abort pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid     <= 1'b0;
            rsp_is_err    <= 1'b0;
            rsp_c         <= '0;
            rsp_flags     <= '0;
            rsp_err_flags <= '0;
            rsp_chk_ok    <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= w_abort;
            overrun   <= 1'b0;
            if (w_done) begin
                if (!rsp_valid || rsp_ready) begin
                    rsp_valid     <= 1'b1;
                    rsp_is_err    <= w_new_is_err;
                    rsp_c         <= w_new_c;
                    rsp_flags     <= w_new_flags;
                    rsp_err_flags <= w_new_err_flags;
                    rsp_chk_ok    <= w_new_chk_ok;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_rsp_rx.sv
// Self-checking bench for mtm_alu_rsp_rx: directed scenarios plus randomized
// frame streams compared every cycle against a frame-level reference model.
module tb_mtm_alu_rsp_rx;

    localparam int GAP = 64;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        sout      = 1'b1;
    logic        rsp_ready = 1'b0;
    logic        rsp_valid;
    logic        rsp_is_err;
    logic [31:0] rsp_c;
    logic [3:0]  rsp_flags;
    logic [5:0]  rsp_err_flags;
    logic        rsp_chk_ok;
    logic        frame_err;
    logic        overrun;

    always #5 clk = ~clk;

    mtm_alu_rsp_rx #(.GAP_TIMEOUT(GAP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sout          (sout),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_is_err    (rsp_is_err),
        .rsp_c         (rsp_c),
        .rsp_flags     (rsp_flags),
        .rsp_err_flags (rsp_err_flags),
        .rsp_chk_ok    (rsp_chk_ok),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC by polynomial long division of {C,0,flags,000} by 1011.
    function automatic logic [2:0] model_crc(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] r;
        r = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        end
        return r[2:0];
    endfunction

    // Stimulus-side frame events handed to the model.
    int         ready_mode = 0;   // 0: low, 1: high, 2: random
    logic       line_busy  = 1'b0;
    int         ev_seq     = 0;
    logic       ev_type    = 1'b0;
    logic [7:0] ev_payload = 8'h00;
    logic       ev_stop    = 1'b1;
    logic       cmp_en     = 1'b0;

    // Model outputs.
    logic        exp_valid  = 1'b0;
    logic        exp_is_err = 1'b0;
    logic        exp_chk    = 1'b0;
    logic        exp_ferr   = 1'b0;
    logic        exp_ovr    = 1'b0;
    logic [31:0] exp_c      = '0;
    logic [3:0]  exp_flags  = '0;
    logic [5:0]  exp_eflags = '0;
    int          words      = 0;
    int          idle_run   = 0;
    int          seen_seq   = 0;
    logic [7:0]  bytes_q [4];

    // Frame-level reference model.
    always @(posedge clk or negedge rst_n) begin : model
        logic        done, abort, n_err, n_chk;
        logic [31:0] n_c;
        logic [3:0]  n_f;
        logic [5:0]  n_ef;
        if (!rst_n) begin
            exp_valid = 0; exp_is_err = 0; exp_chk = 0; exp_ferr = 0; exp_ovr = 0;
            exp_c = 0; exp_flags = 0; exp_eflags = 0;
            words = 0; idle_run = 0;
        end else begin
            done = 0; abort = 0; n_err = 0; n_chk = 0; n_c = 0; n_f = 0; n_ef = 0;
            if (seen_seq != ev_seq) begin
                seen_seq = ev_seq;
                if (!ev_stop) abort = 1;
                else if (ev_type == 1'b0) begin
                    if (words < 4) begin bytes_q[words] = ev_payload; words++; end
                    else abort = 1;
                end else if (ev_payload[7]) begin
                    if (words == 0) begin
                        done = 1; n_err = 1; n_ef = ev_payload[6:1];
                        n_chk = ((^ev_payload) == 1'b0);
                    end else abort = 1;
                end else if (words == 4) begin
                    done = 1;
                    n_c  = {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]};
                    n_f  = ev_payload[6:3];
                    n_chk = (model_crc(n_c, n_f) == ev_payload[2:0]);
                end else abort = 1;
            end else if (line_busy || words == 0) begin
                idle_run = 0;
            end else begin
                idle_run++;
                if (idle_run == GAP) abort = 1;
            end
            if (done || abort) begin words = 0; idle_run = 0; end

            exp_ferr = abort;
            exp_ovr  = 0;
            if (done) begin
                if (!exp_valid || rsp_ready) begin
                    exp_valid = 1; exp_is_err = n_err; exp_c = n_c;
                    exp_flags = n_f; exp_eflags = n_ef; exp_chk = n_chk;
                end else exp_ovr = 1;
            end else if (exp_valid && rsp_ready) exp_valid = 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            check("overrun",   32'(overrun),   32'(exp_ovr));
            if (exp_valid || !rst_n) begin
                check("rsp_is_err",    32'(rsp_is_err),    32'(exp_is_err));
                check("rsp_c",         rsp_c,              exp_c);
                check("rsp_flags",     32'(rsp_flags),     32'(exp_flags));
                check("rsp_err_flags", 32'(rsp_err_flags), 32'(exp_eflags));
                check("rsp_chk_ok",    32'(rsp_chk_ok),    32'(exp_chk));
            end
        end
    end

    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
    end

    task automatic drive(input logic b, input logic busy);
        @(posedge clk);
        #1;
        sout      = b;
        line_busy = busy;
        rsp_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic t, input logic [7:0] p, input logic stop, input logic rdy_stop);
        drive(1'b0, 1'b0);
        drive(t, 1'b1);
        for (int i = 7; i >= 0; i--) drive(p[i], 1'b1);
        if (rdy_stop) ready_mode = 1;
        drive(stop, 1'b1);
        if (rdy_stop) ready_mode = 0;
        ev_type    = t;
        ev_payload = p;
        ev_stop    = stop;
        ev_seq++;
    endtask

    task automatic send_data_rsp(input logic [31:0] c, input logic [3:0] f, input logic [2:0] crc_x,
                                 input int gap, input logic rdy_stop);
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, c[31-8*i -: 8], 1'b1, 1'b0);
            idle(gap);
        end
        send_frame(1'b1, {1'b0, f, model_crc(c, f) ^ crc_x}, 1'b1, rdy_stop);
    endtask

    // Sample settled outputs one cycle after the last driven bit.
    task automatic look();
        idle(1);
        @(negedge clk);
        #1;
    endtask

    task automatic accept();
        ready_mode = 1;
        idle(1);
        ready_mode = 0;
        idle(1);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin : stim
        int         f0, o0;
        logic [31:0] c;
        logic [3:0]  f;
        logic [2:0]  x;
        logic [7:0]  p;
        logic        t, stop;

        // Model pins: hand-derived CRC3 values.
        check("model_crc C=3",  32'(model_crc(32'h3, 4'h0)), 32'h6);
        check("model_crc C=1",  32'(model_crc(32'h1, 4'h0)), 32'h2);

        // Reset with the line held low; line must stay ignored after release.
        #2;
        sout   = 1'b0;
        rst_n  = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_c",     rsp_c,          32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) drive(1'b0, 1'b0);
        idle(80);
        check("low line after reset no frame_err", 32'(ferr_cnt), 32'h0);

        // Clean data response C=3.
        send_data_rsp(32'h3, 4'h0, 3'b000, 0, 1'b0);
        look();
        check("c3 valid",  32'(rsp_valid),  32'h1);
        check("c3 rsp_c",  rsp_c,           32'h3);
        check("c3 chk_ok", 32'(rsp_chk_ok), 32'h1);
        check("c3 is_err", 32'(rsp_is_err), 32'h0);
        accept();

        // Same response with CRC bit 0 inverted.
        f0 = ferr_cnt;
        send_data_rsp(32'h3, 4'h0, 3'b001, 0, 1'b0);
        look();
        check("badcrc valid",  32'(rsp_valid),      32'h1);
        check("badcrc rsp_c",  rsp_c,               32'h3);
        check("badcrc chk_ok", 32'(rsp_chk_ok),     32'h0);
        check("badcrc no frame_err", 32'(ferr_cnt - f0), 32'h0);
        accept();

        // Error response 1_100100_1.
        send_frame(1'b1, 8'b1_100100_1, 1'b1, 1'b0);
        look();
        check("err is_err",    32'(rsp_is_err),    32'h1);
        check("err err_flags", 32'(rsp_err_flags), 32'h24);
        check("err chk_ok",    32'(rsp_chk_ok),    32'h1);
        check("err rsp_c",     rsp_c,              32'h0);
        accept();

        // Gap of 62 high cycles stays within the limit.
        f0 = ferr_cnt;
        send_frame(1'b0, 8'hDE, 1'b1, 1'b0);
        send_frame(1'b0, 8'hAD, 1'b1, 1'b0);
        idle(62);
        send_frame(1'b0, 8'hBE, 1'b1, 1'b0);
        send_frame(1'b0, 8'hEF, 1'b1, 1'b0);
        send_frame(1'b1, {1'b0, 4'hA, model_crc(32'hDEADBEEF, 4'hA)}, 1'b1, 1'b0);
        look();
        check("gap62 no frame_err", 32'(ferr_cnt - f0), 32'h0);
        check("gap62 rsp_c",        rsp_c,              32'hDEADBEEF);
        check("gap62 flags",        32'(rsp_flags),     32'hA);
        accept();

        // Two DATA frames then 64 high cycles: timeout, then clean recovery.
        f0 = ferr_cnt;
        send_frame(1'b0, 8'h11, 1'b1, 1'b0);
        send_frame(1'b0, 8'h22, 1'b1, 1'b0);
        idle(64);
        idle(4);
        check("gap64 frame_err", 32'(ferr_cnt - f0), 32'h1);
        check("gap64 no valid",  32'(rsp_valid),     32'h0);
        send_data_rsp(32'h1234_5678, 4'h5, 3'b000, 2, 1'b0);
        look();
        check("after gap rsp_c",  rsp_c,           32'h1234_5678);
        check("after gap chk_ok", 32'(rsp_chk_ok), 32'h1);
        accept();

        // Protocol errors: stop bit 0, CTL bit7=0 at word 1, DATA at word 4.
        f0 = ferr_cnt;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        idle(2);
        send_frame(1'b0, 8'h01, 1'b1, 1'b0);
        send_frame(1'b1, 8'h06, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(i), 1'b1, 1'b0);
        idle(4);
        check("protocol frame_err count", 32'(ferr_cnt - f0), 32'h3);
        check("protocol no valid",        32'(rsp_valid),     32'h0);

        // Back-to-back responses with consumer stalled.
        o0 = ovr_cnt;
        send_data_rsp(32'hCAFE_0001, 4'h1, 3'b000, 0, 1'b0);
        send_data_rsp(32'hCAFE_0002, 4'h2, 3'b000, 0, 1'b0);
        look();
        check("overrun count", 32'(ovr_cnt - o0), 32'h1);
        check("overrun held",  rsp_c,             32'hCAFE_0001);

        // Completion coinciding with handshake replaces the held response.
        o0 = ovr_cnt;
        send_data_rsp(32'hCAFE_0003, 4'h3, 3'b000, 0, 1'b1);
        look();
        check("coincide no overrun", 32'(ovr_cnt - o0), 32'h0);
        check("coincide valid",      32'(rsp_valid),    32'h1);
        check("coincide rsp_c",      rsp_c,             32'hCAFE_0003);

        // Reset during byte 3 while a response is held.
        send_frame(1'b0, 8'hAA, 1'b1, 1'b0);
        send_frame(1'b0, 8'hBB, 1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset rsp_valid", 32'(rsp_valid), 32'h0);
        check("midreset rsp_c",     rsp_c,          32'h0);
        check("midreset flags",     32'(rsp_flags), 32'h0);
        sout      = 1'b1;
        line_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        send_data_rsp(32'h8000_00FF, 4'hF, 3'b000, 1, 1'b0);
        look();
        check("postreset rsp_c",  rsp_c,           32'h8000_00FF);
        check("postreset chk_ok", 32'(rsp_chk_ok), 32'h1);
        accept();

        // Randomized frame streams with random consumer backpressure.
        ready_mode = 2;
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                p    = {1'b1, 6'($urandom), 1'($urandom)};
                t    = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
                stop = ($urandom_range(0, 39) != 0);
                send_frame(t, p, stop, 1'b0);
            end else begin
                c = $urandom;
                f = 4'($urandom);
                x = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                for (int i = 0; i < 5; i++) begin
                    if (i < 4) begin
                        t = 1'b0;
                        p = c[31-8*i -: 8];
                    end else begin
                        t = 1'b1;
                        p = {1'b0, f, model_crc(c, f) ^ x};
                    end
                    if ($urandom_range(0, 39) == 0) t = ~t;
                    stop = ($urandom_range(0, 39) != 0);
                    send_frame(t, p, stop, 1'b0);
                    idle(($urandom_range(0, 31) == 0) ? 66 + $urandom_range(0, 8) : $urandom_range(0, 5));
                end
            end
            idle($urandom_range(0, 12));
        end
        ready_mode = 1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
